branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised execute-stage branch resolver with a bimodal branch history table (BHT) of 2-bit saturating counters. It provides a zero-latency taken/not-taken prediction to the fetch stage and resolves conditional branches and JALR in EX. It raises a redirect on misprediction and updates the BHT at the clock edge. Two saturating performance counters track resolved and mispredicted branches.

## Interface
- XLEN, 32: datapath width.
- BHT_ENTRIES, 64: BHT depth; power of two, ≥ 2. IDX = log2(BHT_ENTRIES).
- CNT_WIDTH, 32: performance counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  fetch PC for lookup.
- if_predict_taken  out  1  MSB of BHT[if_pc[IDX+1:2]].
- ex_valid  in  1  EX instruction is valid.
- ex_is_branch  in  1  conditional branch (IS_BRANCH control bit).
- ex_is_jalr  in  1  JALR.
- ex_funct3  in  3  branch condition.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate  in  XLEN  operands.
- ex_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- stall  in  1  freezes BHT and counter updates.
- pc_src  out  1  redirect fetch to new_pc.
- new_pc  out  XLEN  redirect target; 0 when pc_src = 0.
- flush  out  1  squash younger instructions; equals pc_src.
- mispredict  out  1  conditional-branch misprediction.
- perf_branches  out  CNT_WIDTH  resolved conditional branches.
- perf_mispredicts  out  CNT_WIDTH  mispredicted conditional branches.

## Operation
- Condition (`taken`) by funct3:
  - 000 beq: rs1 == rs2.
  - 001 bne: rs1 != rs2.
  - 100 blt: signed rs1 < rs2.
  - 101 bge: signed rs1 >= rs2.
  - 110 bltu: unsigned rs1 < rs2.
  - 111 bgeu: unsigned rs1 >= rs2.
  - 010, 011: invalid. The instruction is treated as a non-branch: no outputs, no BHT update, no counting.
- A branch is valid when ex_valid & ex_is_branch & funct3 is valid.
- Valid branch with taken != ex_pred_taken:
  - pc_src = flush = mispredict = 1.
  - new_pc = taken ? ex_pc + ex_immediate : ex_pc + 4. XLEN-bit addition; the carry is discarded.
- Valid branch that was correctly predicted: all redirect outputs are 0. Fetch has already followed the prediction.
- ex_valid & ex_is_jalr: pc_src = flush = 1, mispredict = 0, new_pc = (rs1 + imm) & ~1. JALR is not counted and does not touch the BHT.
- If ex_is_branch and ex_is_jalr are both set, the branch takes priority.
- BHT entry states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- On the edge with a valid branch and !stall, BHT[ex_pc[IDX+1:2]] is updated:
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- Performance counters, on the same edge and conditions:
  - perf_branches += 1.
  - perf_mispredicts += 1 if mispredicted.
  - Both saturate at all-ones and never wrap.
- stall = 1 suppresses BHT and counter updates only; the combinational redirect outputs are still driven.

## Timing
- Prediction lookup and EX resolution are both combinational, with 0-cycle latency.
- A BHT write is visible on if_predict_taken from the cycle after the edge.
- If the IF lookup and the EX update hit the same index in the same cycle, the lookup returns the pre-update value.
- Aliasing: PCs sharing bits [IDX+1:2] share one entry. This is intended behaviour.
- Reset (asserted asynchronously at any time, including mid-branch):
  - All BHT entries are set to 01, so if_predict_taken = 0.
  - perf counters are set to 0.
  - pc_src, flush, mispredict and new_pc are 0 while rst_n = 0.
  - Normal operation resumes on the first rising edge after rst_n deasserts.

## Test plan
- Reset, then if_pc = 0x100 → if_predict_taken = 0. Then beq at ex_pc = 0x100, rs1 = rs2 = 5, imm = 0x20, pred 0 → pc_src = flush = mispredict = 1, new_pc = 0x120. Next cycle → if_predict_taken = 1, perf_branches = 1, perf_mispredicts = 1.
- Three more taken branches at 0x100 saturate the entry at 11. Then a not-taken bne (rs1 = rs2) with pred 1 → new_pc = 0x104, mispredict = 1. Entry becomes 10, so the prediction is still 1.
- rs1 = 0xFFFFFFFF, rs2 = 1, imm = 8, pc = 0x40, pred 0:
  - blt → redirect to 0x48.
  - bltu → no redirect.
  - bgeu → redirect.
  - funct3 = 010 → no outputs, counters unchanged.
- jalr with rs1 = 0x1001, imm = 4 → pc_src = 1, new_pc = 0x1004, mispredict = 0, counters unchanged. Taken branch at 0x100 with stall = 1 → redirect asserted, but the entry and counters are unchanged next cycle.
- BHT_ENTRIES = 64: train 0x100 to taken, then check if_pc = 0x200 (aliases to index 0) → predicts 1. With CNT_WIDTH = 4, 20 branches → perf_branches stays at 15.
- Assert rst_n low mid-cycle during a mispredicted branch → outputs drop to 0 immediately, counters read 0, and the trained entry predicts 0 after release.

Source files
------------

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit
//  Purpose  : Execute-stage branch resolver with a bimodal BHT of 2-bit
//             saturating counters, fetch-side prediction lookup, redirect
//             generation and saturating branch performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_predict_taken,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_rs1_data,
  input  logic [XLEN-1:0]      ex_rs2_data,
  input  logic [XLEN-1:0]      ex_immediate,
  input  logic                 ex_pred_taken,
  input  logic                 stall,
  output logic                 pc_src,
  output logic [XLEN-1:0]      new_pc,
  output logic                 flush,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] perf_branches,
  output logic [CNT_WIDTH-1:0] perf_mispredicts
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] BHT_RESET = 2'b01;

  logic [1:0]      r_bht [BHT_ENTRIES];
  logic [IDX-1:0]  w_if_idx;
  logic [IDX-1:0]  w_ex_idx;
  logic            w_f3_valid;
  logic            w_taken;
  logic            w_br_valid;
  logic            w_jalr_fire;
  logic            w_mispredict;
  logic            w_update;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jalr_target;

  // Word-aligned PC bits select the BHT entry; aliasing PCs share an entry.
  assign w_if_idx = if_pc[IDX+1:2];
  assign w_ex_idx = ex_pc[IDX+1:2];

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign if_predict_taken = r_bht[w_if_idx][1];

  // Branch condition evaluation; funct3 010/011 are not branches at all.
  always_comb begin
    w_f3_valid = 1'b1;
    w_taken    = 1'b0;
    case (ex_funct3)
      F3_BEQ:  w_taken = (ex_rs1_data == ex_rs2_data);
      F3_BNE:  w_taken = (ex_rs1_data != ex_rs2_data);
      F3_BLT:  w_taken = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
      F3_BGE:  w_taken = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
      F3_BLTU: w_taken = (ex_rs1_data <  ex_rs2_data);
      F3_BGEU: w_taken = (ex_rs1_data >= ex_rs2_data);
      default: w_f3_valid = 1'b0;
    endcase
  end

  // A resolving branch wins over JALR when both control bits are set.
  assign w_br_valid    = ex_valid & ex_is_branch & w_f3_valid;
  assign w_jalr_fire   = ex_valid & ex_is_jalr & ~w_br_valid;
  assign w_mispredict  = w_br_valid & (w_taken != ex_pred_taken);
  assign w_update      = w_br_valid & ~stall;
  assign w_br_target   = w_taken ? (ex_pc + ex_immediate) : (ex_pc + XLEN'(4));
  assign w_jalr_target = (ex_rs1_data + ex_immediate) & ~XLEN'(1);

  // Redirect outputs, held at zero while reset is asserted.
  always_comb begin
    pc_src     = 1'b0;
    mispredict = 1'b0;
    new_pc     = '0;
    if (rst_n) begin
      if (w_mispredict) begin
        pc_src     = 1'b1;
        mispredict = 1'b1;
        new_pc     = w_br_target;
      end else if (w_jalr_fire) begin
        pc_src     = 1'b1;
        new_pc     = w_jalr_target;
      end
    end
  end

  assign flush = pc_src;

  // BHT training: saturating increment on taken, decrement on not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_bht[i] <= BHT_RESET;
      end
    end else if (w_update) begin
      if (w_taken) begin
        if (r_bht[w_ex_idx] != 2'b11) begin
          r_bht[w_ex_idx] <= r_bht[w_ex_idx] + 2'b01;
        end
      end else if (r_bht[w_ex_idx] != 2'b00) begin
        r_bht[w_ex_idx] <= r_bht[w_ex_idx] - 2'b01;
      end
    end
  end

  // Performance counters; both stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (w_update) begin
      if (perf_branches != '1) begin
        perf_branches <= perf_branches + CNT_WIDTH'(1);
      end
      if (w_mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predict_unit
//  Purpose  : Self-checking bench for branch_predict_unit: a behavioural
//             model checked every cycle plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int XLEN = 32;
  localparam int NENT = 64;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] if_pc;
  logic            if_predict_taken;
  logic            ex_valid, ex_is_branch, ex_is_jalr, ex_pred_taken, stall;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_immediate;
  logic            pc_src, flush, mispredict;
  logic [XLEN-1:0] new_pc;
  logic [CW-1:0]   perf_branches, perf_mispredicts;

  int checks   = 0;
  int failures = 0;

  // model state: counter value 0..3 per entry, plain integer counters
  int m_bht [NENT];
  int m_pb, m_pm;

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(NENT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_predict_taken(if_predict_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jalr(ex_is_jalr),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_immediate(ex_immediate),
    .ex_pred_taken(ex_pred_taken), .stall(stall), .pc_src(pc_src),
    .new_pc(new_pc), .flush(flush), .mispredict(mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_bht[i] = 1;
    m_pb = 0;
    m_pm = 0;
  endtask

  function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(negedge rst_n);
      model_reset();
    end
  end

  // Model compare: mid-cycle, check every output, then advance the model
  initial begin
    bit brv, tk, jv, mis;
    logic [31:0] epc, sum;
    int idx;
    forever begin
      @(negedge clk);
      brv = ex_valid && ex_is_branch && (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
      tk  = cond_taken(ex_funct3, ex_rs1_data, ex_rs2_data);
      jv  = ex_valid && ex_is_jalr && !brv;
      mis = brv && (tk != ex_pred_taken);
      epc = 32'h0;
      if (rst_n && mis) epc = tk ? ex_pc + ex_immediate : ex_pc + 32'd4;
      else if (rst_n && jv) begin
        sum = ex_rs1_data + ex_immediate;
        epc = {sum[31:1], 1'b0};
      end
      chk("m_predict", 32'(if_predict_taken), 32'(m_bht[(if_pc >> 2) % NENT] >= 2));
      chk("m_pc_src", 32'(pc_src), 32'(rst_n && (mis || jv)));
      chk("m_flush", 32'(flush), 32'(rst_n && (mis || jv)));
      chk("m_mispredict", 32'(mispredict), 32'(rst_n && mis));
      chk("m_new_pc", new_pc, epc);
      chk("m_perf_br", 32'(perf_branches), 32'(m_pb));
      chk("m_perf_mis", 32'(perf_mispredicts), 32'(m_pm));
      if (rst_n && brv && !stall) begin
        idx = (ex_pc >> 2) % NENT;
        if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
        else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
        if (m_pb < CMAX) m_pb++;
        if (mis && m_pm < CMAX) m_pm++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit br, input bit jr, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input bit pred, input bit stl);
    ex_valid = v; ex_is_branch = br; ex_is_jalr = jr; ex_funct3 = f3;
    ex_pc = pc; ex_rs1_data = a; ex_rs2_data = b; ex_immediate = imm;
    ex_pred_taken = pred; stall = stl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  // Directed stimulus with hand-computed literal expectations
  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    idle();
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_predict", 32'(if_predict_taken), 32'd0);
    chk("rst_perf_br", 32'(perf_branches), 32'd0);

    // first taken beq mispredicted
    step();
    drive(1, 1, 0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 0, 0);
    #1;
    chk("beq_pc_src", 32'(pc_src), 32'd1);
    chk("beq_flush", 32'(flush), 32'd1);
    chk("beq_mis", 32'(mispredict), 32'd1);
    chk("beq_new_pc", new_pc, 32'h120);
    step();
    idle();
    #1;
    chk("beq_trained", 32'(if_predict_taken), 32'd1);
    chk("beq_perf_br", 32'(perf_branches), 32'd1);
    chk("beq_perf_mis", 32'(perf_mispredicts), 32'd1);

    // saturate at strong-T, then a single not-taken bne
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1, 1, 0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1, 0);
      #1;
      chk("sat_no_redirect", 32'(pc_src), 32'd0);
    end
    step();
    drive(1, 1, 0, 3'd1, 32'h100, 32'd7, 32'd7, 32'h20, 1, 0);
    #1;
    chk("bne_new_pc", new_pc, 32'h104);
    chk("bne_mis", 32'(mispredict), 32'd1);
    step();
    idle();
    #1;
    chk("bne_still_taken", 32'(if_predict_taken), 32'd1);
    chk("bne_perf_br", 32'(perf_branches), 32'd5);
    chk("bne_perf_mis", 32'(perf_mispredicts), 32'd2);

    // signed vs unsigned compares
    step();
    drive(1, 1, 0, 3'd4, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'd8, 0, 0);
    #1;
    chk("blt_pc_src", 32'(pc_src), 32'd1);
    chk("blt_new_pc", new_pc, 32'h48);
    step();
    drive(1, 1, 0, 3'd6, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'd8, 0, 0);
    #1;
    chk("bltu_pc_src", 32'(pc_src), 32'd0);
    chk("bltu_new_pc", new_pc, 32'h0);
    step();
    drive(1, 1, 0, 3'd7, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'd8, 0, 0);
    #1;
    chk("bgeu_pc_src", 32'(pc_src), 32'd1);
    chk("bgeu_new_pc", new_pc, 32'h48);
    step();
    drive(1, 1, 0, 3'd2, 32'h40, 32'hFFFF_FFFF, 32'd1, 32'd8, 0, 0);
    #1;
    chk("f3_010_pc_src", 32'(pc_src), 32'd0);
    chk("f3_010_mis", 32'(mispredict), 32'd0);
    step();
    idle();
    #1;
    chk("f3_010_perf_br", 32'(perf_branches), 32'd8);
    chk("f3_010_perf_mis", 32'(perf_mispredicts), 32'd4);

    // jalr
    step();
    drive(1, 0, 1, 3'd0, 32'h500, 32'h1001, 32'd0, 32'd4, 0, 0);
    #1;
    chk("jalr_pc_src", 32'(pc_src), 32'd1);
    chk("jalr_new_pc", new_pc, 32'h1004);
    chk("jalr_mis", 32'(mispredict), 32'd0);

    // stalled taken branch at a weak-NT entry
    step();
    drive(1, 1, 0, 3'd0, 32'h108, 32'd3, 32'd3, 32'h20, 0, 1);
    #1;
    chk("stall_pc_src", 32'(pc_src), 32'd1);
    chk("stall_new_pc", new_pc, 32'h128);
    step();
    idle();
    if_pc = 32'h108;
    #1;
    chk("stall_entry", 32'(if_predict_taken), 32'd0);
    chk("stall_perf_br", 32'(perf_branches), 32'd8);

    // aliasing: 0x200 shares index 0 with 0x100
    if_pc = 32'h200;
    #1;
    chk("alias_predict", 32'(if_predict_taken), 32'd1);

    // counter saturation: 12 more correctly predicted branches
    for (int i = 0; i < 12; i++) begin
      step();
      drive(1, 1, 0, 3'd0, 32'h10, 32'd1, 32'd1, 32'h8, 1, 0);
    end
    step();
    idle();
    #1;
    chk("sat_perf_br", 32'(perf_branches), 32'd15);
    chk("sat_perf_mis", 32'(perf_mispredicts), 32'd4);

    // asynchronous reset in the middle of a mispredicted branch
    if_pc = 32'h100;
    step();
    drive(1, 1, 0, 3'd0, 32'h100, 32'd9, 32'd9, 32'h20, 0, 0);
    #1;
    chk("pre_rst_pc_src", 32'(pc_src), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_pc_src", 32'(pc_src), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_mis", 32'(mispredict), 32'd0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_perf_br2", 32'(perf_branches), 32'd0);
    step();
    idle();
    rst_n = 1'b1;
    #1;
    chk("rst_entry", 32'(if_predict_taken), 32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
